// File: rtl/mul_hilo_pkg.sv
// Shared widths, command encodings and FSM states for the HI/LO multiply unit.
package mul_hilo_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 3;

  localparam logic [OP_W-1:0] OP_MULT = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MTHI = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MTLO = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MFHI = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MFLO = OP_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mul_hilo_unit_if.sv
// Command/response handshake bundle between ALU issue and the HI/LO unit.
interface mul_hilo_unit_if
  import mul_hilo_pkg::*;
  ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mul_hilo_unit_tree_multiplier32.sv
// Combinational signed 32x32 -> 64 multiplier; its depth is covered by the multicycle wait.
module tree_multiplier32
  import mul_hilo_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [PROD_W-1:0] p_o
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  assign a_ext = PROD_W'($signed(a_i));
  assign b_ext = PROD_W'($signed(b_i));
  assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/mul_hilo_unit.sv
// Sequences MULT and HI/LO move commands: registered multiplier operands,
// multicycle product capture, architectural HI/LO and one response per command.
module mul_hilo_unit
  import mul_hilo_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_hilo_unit_if.slave    bus,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PROD_W-1:0] prod;
  logic              accept;

  tree_multiplier32 u_mult (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (prod)
  );

  // A draining response frees the unit in the same cycle.
  assign bus.in_ready  = (state_q == IDLE) || ((state_q == RESP) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == RESP);
  assign bus.out_data  = data_q;
  assign hi            = hi_q;
  assign lo            = lo_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    data_d  = data_q;

    case (state_q)
      MUL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          hi_d    = prod[PROD_W-1:DATA_W];
          lo_d    = prod[DATA_W-1:0];
          data_d  = prod[DATA_W-1:0];
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // Dispatch overrides the drain path when a command is taken back-to-back.
    if (accept) begin
      case (bus.in_op)
        OP_MULT: begin
          op_a_d  = bus.in_a;
          op_b_d  = bus.in_b;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
          state_d = MUL;
        end
        OP_MTHI: begin
          hi_d    = bus.in_a;
          data_d  = bus.in_a;
          state_d = RESP;
        end
        OP_MTLO: begin
          lo_d    = bus.in_a;
          data_d  = bus.in_a;
          state_d = RESP;
        end
        OP_MFHI: begin
          data_d  = hi_q;
          state_d = RESP;
        end
        OP_MFLO: begin
          data_d  = lo_q;
          state_d = RESP;
        end
        default: begin
          data_d  = '0;
          state_d = RESP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
    end
  end

endmodule
